// File: rtl/sd_framer_pkg.sv
// sd_framer_pkg: shared types and constants for the sigma-delta power framer.
// Holds serializer state encoding, status byte layout and byte-count helper.
package sd_framer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_STAT = 2'd2,
        S_DATA = 2'd3
    } ser_state_e;

    // Status byte: {mode, overrun, 0, seq[4:0]}
    localparam int STAT_MODE_BIT = 7;
    localparam int STAT_OVR_BIT  = 6;
    localparam int STAT_SEQ_W    = 5;

    // Bytes needed per channel for a (win_log2+1)-bit count
    function automatic int bpc_of(input int win_log2);
        return (win_log2 + 1 + 7) / 8;
    endfunction

endpackage

// File: rtl/sd_chan_accum.sv
// sd_chan_accum: per-channel window accumulator (ones or transition count).
// Ports: clk, rst (async active-low), en_i, mode_i (effective mode this
// cycle), wrap_i (window end), sig_i (bitstream), total_o (acc + this
// cycle's contribution, used as the snapshot value at window end).
module sd_chan_accum
    import sd_framer_pkg::*;
#(
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          mode_i,
    input  logic          wrap_i,
    input  logic          sig_i,
    output logic [CW-1:0] total_o
);

    logic [CW-1:0] acc_q;
    logic [CW-1:0] acc_d;
    logic          prev_q;
    logic          prev_v_q;
    logic          inc;

    // Transitions are only counted once prev holds a real sample.
    always_comb begin
        inc     = mode_i ? (prev_v_q & (sig_i ^ prev_q)) : sig_i;
        total_o = acc_q + CW'(inc);
        acc_d   = acc_q;
        if (!en_i || wrap_i) begin
            acc_d = '0;
        end else begin
            acc_d = total_o;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            prev_q   <= 1'b0;
            prev_v_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (en_i) begin
                prev_q   <= sig_i;
                prev_v_q <= 1'b1;
            end else begin
                prev_v_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sd_power_framer.sv
// sd_power_framer: multi-channel sigma-delta window statistics with a framed
// byte stream output. Ports: clk, rst (async active-low), en, mode, sig,
// ovr_clr in; tx_data/tx_valid/tx_ready stream; frame_done, overrun out.
module sd_power_framer
    import sd_framer_pkg::*;
#(
    parameter int          CHANNELS = 2,
    parameter int          WIN_LOG2 = 10,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [CHANNELS-1:0] sig,
    input  logic                ovr_clr,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                frame_done,
    output logic                overrun
);

    localparam int CW  = WIN_LOG2 + 1;
    localparam int BPC = bpc_of(WIN_LOG2);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CHW-1:0]      CH_LAST = CHW'(CHANNELS - 1);
    localparam logic [CHW-1:0]      CH_ONE  = CHW'(1);
    localparam logic [1:0]          B_LAST  = 2'(BPC - 1);
    localparam logic [WIN_LOG2-1:0] W_ONE   = WIN_LOG2'(1);
    localparam logic [STAT_SEQ_W-1:0] SEQ_ONE = STAT_SEQ_W'(1);

    logic [WIN_LOG2-1:0]         wctr_q;
    logic                        mode_lat_q;
    logic                        wctr_zero;
    logic                        mode_eff;
    logic                        win_end;
    logic [CHANNELS-1:0][CW-1:0] total;

    ser_state_e                  state_q, state_d;
    logic [7:0]                  tx_data_q, tx_data_d;
    logic                        tx_valid_q, tx_valid_d;
    logic [CHW-1:0]              ch_q, ch_d, nxt_ch;
    logic [1:0]                  bsel_q, bsel_d, nxt_b;
    logic [STAT_SEQ_W-1:0]       seq_q, seq_d;
    logic [CHANNELS-1:0][CW-1:0] snap_q, snap_d;
    logic                        fmode_q, fmode_d;
    logic                        ovr_q, ovr_d;

    logic                        hs;
    logic                        last_byte;
    logic                        done;
    logic                        accept;
    logic [7:0]                  stat_byte;
    logic [31:0]                 data_word;
    logic [7:0]                  data_byte;

    // ---------------- window timing ----------------
    // The wctr==0 cycle uses the live mode so the whole window is counted
    // under the mode that gets latched for it.
    assign wctr_zero = (wctr_q == '0);
    assign mode_eff  = wctr_zero ? mode : mode_lat_q;
    assign win_end   = en & (&wctr_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wctr_q     <= '0;
            mode_lat_q <= 1'b0;
        end else begin
            wctr_q <= en ? (wctr_q + W_ONE) : '0;
            if (wctr_zero) begin
                mode_lat_q <= mode;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        sd_chan_accum #(.CW(CW)) u_acc (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en),
            .mode_i  (mode_eff),
            .wrap_i  (win_end),
            .sig_i   (sig[g]),
            .total_o (total[g])
        );
    end

    // ---------------- serializer ----------------
    assign hs        = tx_valid_q & tx_ready;
    assign last_byte = (ch_q == CH_LAST) && (bsel_q == 2'd0);
    assign done      = (state_q == S_DATA) & hs & last_byte;
    // A finishing frame frees the serializer in the same cycle.
    assign accept    = win_end & ((state_q == S_IDLE) | done);

    always_comb begin
        stat_byte                   = '0;
        stat_byte[STAT_MODE_BIT]    = fmode_q;
        stat_byte[STAT_OVR_BIT]     = ovr_q;
        stat_byte[STAT_SEQ_W-1:0]   = seq_q;

        nxt_ch = ch_q;
        nxt_b  = B_LAST;
        if (state_q == S_STAT) begin
            nxt_ch = '0;
        end else if (bsel_q != 2'd0) begin
            nxt_b = bsel_q - 2'd1;
        end else if (!last_byte) begin
            nxt_ch = ch_q + CH_ONE;
        end
        data_word = 32'(snap_q[nxt_ch]);
        data_byte = data_word[{nxt_b, 3'b000} +: 8];
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        ch_d       = ch_q;
        bsel_d     = bsel_q;
        seq_d      = seq_q;
        snap_d     = snap_q;
        fmode_d    = fmode_q;
        ovr_d      = (win_end & ~accept) | (ovr_q & ~ovr_clr);

        unique case (state_q)
            S_IDLE: begin
            end
            S_HDR: begin
                if (hs) begin
                    state_d   = S_STAT;
                    tx_data_d = stat_byte;
                end
            end
            S_STAT: begin
                if (hs) begin
                    state_d   = S_DATA;
                    ch_d      = nxt_ch;
                    bsel_d    = nxt_b;
                    tx_data_d = data_byte;
                end
            end
            S_DATA: begin
                if (hs) begin
                    if (last_byte) begin
                        state_d    = S_IDLE;
                        tx_valid_d = 1'b0;
                        seq_d      = seq_q + SEQ_ONE;
                    end else begin
                        ch_d      = nxt_ch;
                        bsel_d    = nxt_b;
                        tx_data_d = data_byte;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        if (accept) begin
            state_d    = S_HDR;
            tx_valid_d = 1'b1;
            tx_data_d  = HDR_BYTE;
            snap_d     = total;
            fmode_d    = mode_lat_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ch_q       <= '0;
            bsel_q     <= '0;
            seq_q      <= '0;
            snap_q     <= '0;
            fmode_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ch_q       <= ch_d;
            bsel_q     <= bsel_d;
            seq_q      <= seq_d;
            snap_q     <= snap_d;
            fmode_q    <= fmode_d;
            ovr_q      <= ovr_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign frame_done = done;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sd_power_framer.sv
// tb_sd_power_framer: directed scenarios plus random run for sd_power_framer,
// checked against a frame-level behavioural model (queues of expected bytes).
module tb_sd_power_framer;

    localparam int CH   = 2;
    localparam int WL   = 4;
    localparam int WIN  = 1 << WL;
    localparam int BPC  = (WL + 8) / 8;
    localparam int FLEN = 2 + CH * BPC;
    localparam logic [7:0] HDR = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic [CH-1:0] sig = '0;
    logic          ovr_clr = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          frame_done;
    logic          overrun;

    sd_power_framer #(.CHANNELS(CH), .WIN_LOG2(WL), .HDR_BYTE(HDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sig        (sig),
        .ovr_clr    (ovr_clr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] q[$];
    int  m_w, m_seq;
    bit  m_pv, m_ml, m_fmode, m_ovr;
    int  m_cnt[CH];
    bit  m_prev[CH];

    logic [7:0] log_b[$];
    bit         log_d[$];

    task automatic m_reset();
        q.delete();
        m_w = 0; m_seq = 0; m_pv = 0; m_ml = 0; m_fmode = 0; m_ovr = 0;
        for (int c = 0; c < CH; c++) begin
            m_cnt[c] = 0; m_prev[c] = 0;
        end
    endtask

    task automatic model_step(input bit hs);
        bit wend;
        bit set;
        wend = 0;
        set  = 0;
        if (hs) begin
            void'(q.pop_front());
            if (q.size() == FLEN - 1)
                q[0] = {m_fmode, m_ovr, 1'b0, 5'(m_seq)};
            else if (q.size() == 0)
                m_seq++;
        end
        if (!en) begin
            m_w = 0; m_pv = 0;
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        end else begin
            if (m_w == 0) m_ml = mode;
            for (int c = 0; c < CH; c++) begin
                if (!m_ml) m_cnt[c] += int'(sig[c]);
                else if (m_pv && (sig[c] != m_prev[c])) m_cnt[c]++;
                m_prev[c] = sig[c];
            end
            m_pv = 1;
            m_w++;
            if (m_w == WIN) begin
                m_w = 0; wend = 1;
            end
        end
        if (wend) begin
            if (q.size() == 0) begin
                q.push_back(HDR);
                q.push_back(8'h00);
                for (int c = 0; c < CH; c++)
                    for (int b = BPC - 1; b >= 0; b--)
                        q.push_back(8'((m_cnt[c] >> (8 * b)) & 255));
                m_fmode = m_ml;
            end else begin
                set = 1;
            end
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        end
        if (set) m_ovr = 1;
        else if (ovr_clr) m_ovr = 0;
    endtask

    // One clock: check registered outputs, drive inputs, check frame_done,
    // log handshaken bytes and advance the model.
    task automatic cycle(input logic e, input logic m, input logic [CH-1:0] s,
                         input logic clr, input logic rdy);
        bit hs;
        @(negedge clk);
        check_eq("tx_valid", tx_valid, (q.size() != 0));
        if (q.size() != 0) check_eq("tx_data", tx_data, q[0]);
        check_eq("overrun", overrun, m_ovr);
        en = e; mode = m; sig = s; ovr_clr = clr; tx_ready = rdy;
        #1;
        hs = (q.size() != 0) && rdy;
        check_eq("frame_done", frame_done, hs && (q.size() == 1));
        if (tx_valid && tx_ready) begin
            log_b.push_back(tx_data);
            log_d.push_back(frame_done);
        end
        model_step(hs);
    endtask

    task automatic do_reset();
        en = 0; mode = 0; sig = '0; ovr_clr = 0; tx_ready = 1;
        rst = 0;
        #1;
        check_eq("rst_valid", tx_valid, 0);
        check_eq("rst_data", tx_data, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_done", frame_done, 0);
        m_reset();
        log_b.delete();
        log_d.delete();
        @(negedge clk);
        rst = 1;
    endtask

    function automatic logic [31:0] lb(input int i);
        return (i < log_b.size()) ? 32'(log_b[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] ld(input int i);
        return (i < log_d.size()) ? 32'(log_d[i]) : 32'hDEAD;
    endfunction

    int          p_rdy;
    logic        r_mode;
    logic [CH-1:0] r_sig;

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // ones count
        for (int c = 0; c < 40; c++)
            cycle(1, 0, {~c[0], 1'b1}, 0, 1);
        check_eq("ones_hdr", lb(0), 8'hA5);
        check_eq("ones_stat", lb(1), 8'h00);
        check_eq("ones_ch0", lb(2), 8'h10);
        check_eq("ones_ch1", lb(3), 8'h08);
        check_eq("ones_done3", ld(3), 1);
        check_eq("ones_done2", ld(2), 0);
        check_eq("ones_stat2", lb(5), 8'h01);

        // transition count
        do_reset();
        for (int c = 0; c < 40; c++)
            cycle(1, 1, {c[0], 1'b0}, 0, 1);
        check_eq("tr_stat", lb(1), 8'h80);
        check_eq("tr_ch0", lb(2), 8'h00);
        check_eq("tr_ch1a", lb(3), 8'h0F);
        check_eq("tr_stat2", lb(5), 8'h81);
        check_eq("tr_ch1b", lb(7), 8'h10);

        // backpressure and drops
        do_reset();
        for (int c = 0; c < 72; c++) begin
            cycle(1, 0, 2'($urandom), (c == 60), !(c >= 16 && c < 56));
            if (c == 40 || c == 56) check_eq("bp_hold", tx_data, 8'hA5);
            if (c == 50) check_eq("bp_ovr", overrun, 1);
            if (c == 61) check_eq("bp_clr", overrun, 0);
        end
        check_eq("bp_stat", lb(1), 8'h40);
        check_eq("bp_stat2", lb(5), 8'h01);

        // back-to-back frames
        do_reset();
        for (int c = 0; c < 40; c++) begin
            cycle(1, 0, 2'($urandom), 0, (c < 16) || (c >= 28));
            if (c == 32) begin
                check_eq("b2b_valid", tx_valid, 1);
                check_eq("b2b_hdr", tx_data, 8'hA5);
                check_eq("b2b_ovr", overrun, 0);
            end
        end
        check_eq("b2b_done", ld(3), 1);
        check_eq("b2b_next", lb(4), 8'hA5);

        // reset mid-DATA
        do_reset();
        for (int c = 0; c < 35; c++)
            cycle(1, 0, 2'($urandom), 0, 1);
        check_eq("mid_seq1", lb(5), 8'h01);
        check_eq("mid_indata", tx_valid, 1);
        do_reset();
        for (int c = 0; c < 20; c++)
            cycle(1, 0, 2'b11, 0, 1);
        check_eq("mid_seq0", lb(1), 8'h00);

        // en dropped mid-window
        do_reset();
        for (int c = 0; c < 32; c++) begin
            cycle(!(c >= 8 && c < 11), 0, 2'b11, 0, 1);
            if (c == 26) check_eq("en_nofrm", tx_valid, 0);
            if (c == 27) check_eq("en_frm", tx_valid, 1);
        end
        check_eq("en_ch0", lb(2), 8'h10);
        check_eq("en_ch1", lb(3), 8'h10);

        // mode change mid-window
        do_reset();
        for (int c = 0; c < 40; c++)
            cycle(1, (c >= 7), 2'($urandom), 0, 1);
        check_eq("mc_stat1", lb(1), 8'h00);
        check_eq("mc_stat2", lb(5), 8'h81);

        // random run
        do_reset();
        r_mode = 0;
        r_sig  = '0;
        p_rdy  = 100;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: p_rdy = 100;
                    1: p_rdy = 70;
                    2: p_rdy = 30;
                    default: p_rdy = 5;
                endcase
            end
            if ($urandom_range(0, 99) < 3) r_mode = ~r_mode;
            for (int k = 0; k < CH; k++)
                if ($urandom_range(0, 99) < 40) r_sig[k] = ~r_sig[k];
            cycle($urandom_range(0, 99) >= 2, r_mode, r_sig,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 99) < p_rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
